fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the control decoder.
//  - Holds the program counter (PC) and drives the instruction-memory address.
//  - Presents the fetched 9-bit instruction, with a valid flag, to the decoder.
//  - Redirects the PC through a branch-target lookup table.
//  - Halts when the decoder reports the done instruction.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_unit_branch_lut.sv | 13 +
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// BRANCH_LUT is the program-specific branch-target table.
package fetch_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_IDX_W = 4;
  localparam int LUT_DEPTH = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

  localparam logic [PC_W-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'd16,  10'd24,  10'd32,  10'd40,
    10'd100, 10'd200, 10'd300, 10'd400,
    10'd500, 10'd600, 10'd700, 10'd800,
    10'd900, 10'd1000, 10'd1020, 10'd1023
  };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target lookup: LUT index -> target PC.
module branch_lut #(
  parameter int PC_W      = fetch_pkg::PC_W,
  parameter int LUT_IDX_W = fetch_pkg::LUT_IDX_W
) (
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);
  import fetch_pkg::*;

  assign target_o = PC_W'(BRANCH_LUT[idx_i]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IDLE/RUN/HALT control and next-PC
// selection (sequential, branch-table redirect, hold on stall or halt).
module fetch_unit #(
  parameter int PC_W      = fetch_pkg::PC_W,
  parameter int LUT_IDX_W = fetch_pkg::LUT_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 done_in,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [8:0]           imem_rdata,
  output logic [8:0]           instruction,
  output logic                 instr_valid,
  output logic [PC_W-1:0]      pc,
  output logic                 done
);
  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] branch_target;

  branch_lut #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) u_branch_lut (
    .idx_i    (branch_idx),
    .target_o (branch_target)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latch can form.
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        // done_in outranks a branch; a stall freezes everything, start is ignored
        if (!stall) begin
          if (done_in)           state_d = HALT;
          else if (branch_taken) pc_d    = branch_target;
          else                   pc_d    = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == RUN) && !stall;
  assign done        = (state_q == HALT);
  assign instruction = (state_q == RUN) ? imem_rdata : 9'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a program-level model (running/halted flags,
// integer PC, its own copy of the branch table) is compared every cycle.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [3:0] branch_idx = 4'd0;
  logic       done_in = 1'b0;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic [8:0] instruction;
  logic       instr_valid;
  logic [9:0] pc;
  logic       done;

  logic [8:0] rom [1024];
  assign imem_rdata = rom[imem_addr];

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .done_in      (done_in),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: program is either running, halted, or neither (idle).
  bit m_running;
  bit m_halted;
  int m_pc;
  int exp_lut [16] = '{16, 24, 32, 40, 100, 200, 300, 400,
                       500, 600, 700, 800, 900, 1000, 1020, 1023};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_running = 0;
    m_halted  = 0;
    m_pc      = 0;
  endtask

  task automatic compare_outputs();
    logic [8:0] exp_instr;
    exp_instr = m_running ? rom[m_pc] : 9'h000;
    check("pc",          32'(pc),          32'(m_pc));
    check("imem_addr",   32'(imem_addr),   32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_running && !stall));
    check("done",        32'(done),        32'(m_halted));
    check("instruction", 32'(instruction), 32'(exp_instr));
  endtask

  task automatic model_step(input bit s, input bit st, input bit br, input int idx, input bit dn);
    if (!m_running) begin
      if (s) begin
        m_running = 1;
        m_halted  = 0;
        m_pc      = 0;
      end
    end else if (!st) begin
      if (dn) begin
        m_running = 0;
        m_halted  = 1;
      end else if (br) m_pc = exp_lut[idx];
      else             m_pc = (m_pc + 1) % 1024;
    end
  endtask

  // Entered just after a falling edge; leaves one time unit after the next one.
  task automatic cycle(input bit s = 0, input bit st = 0, input bit br = 0,
                       input int idx = 0, input bit dn = 0);
    start = s; stall = st; branch_taken = br; branch_idx = 4'(idx); done_in = dn;
    #1 compare_outputs();
    @(posedge clk);
    model_step(s, st, br, idx, dn);
    @(negedge clk);
    start = 0; stall = 0; branch_taken = 0; branch_idx = 4'd0; done_in = 0;
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_pc"},    32'(pc),          32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_instr"}, 32'(instruction), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 37 + 5) & 'h1FF);
    rom[0] = 9'h0A4; rom[1] = 9'h05C; rom[2] = 9'h113; rom[3] = 9'h0F0;
    rom[1023] = 9'h1C7;

    // Reset asserted mid-cycle, then idle with no start
    async_reset_check("por");
    repeat (3) cycle();
    check("idle_pc", 32'(pc), 32'd0);

    // Sequential fetch
    cycle(.s(1));
    check("seq0_instr", 32'(instruction), 32'h0A4);
    check("seq0_valid", 32'(instr_valid), 32'd1);
    cycle();
    check("seq1_instr", 32'(instruction), 32'h05C);
    check("seq1_pc",    32'(pc),          32'd1);
    cycle();
    check("seq2_instr", 32'(instruction), 32'h113);
    cycle();
    check("seq3_instr", 32'(instruction), 32'h0F0);
    check("seq3_pc",    32'(pc),          32'd3);
    cycle(); cycle();
    check("pre_br_pc", 32'(pc), 32'd5);

    // Taken branch through LUT[3]
    cycle(.br(1), .idx(3));
    check("br_pc",    32'(pc),          32'd40);
    check("br_valid", 32'(instr_valid), 32'd1);

    // Start while running is ignored
    cycle(.s(1));
    check("start_ignored_pc", 32'(pc), 32'd41);

    // done_in outranks branch_taken
    cycle(.br(1), .idx(0), .dn(1));
    check("prio_done",  32'(done),        32'd1);
    check("prio_pc",    32'(pc),          32'd41);
    check("prio_instr", 32'(instruction), 32'd0);
    cycle();
    check("halt_hold_pc", 32'(pc), 32'd41);

    // Restart from HALT
    cycle(.s(1));
    check("restart_pc",   32'(pc),   32'd0);
    check("restart_done", 32'(done), 32'd0);

    // Stall at pc=7, including stall combined with branch and done
    repeat (7) cycle();
    check("stall_pre_pc", 32'(pc), 32'd7);
    cycle(.st(1));
    cycle(.st(1));
    cycle(.st(1), .br(1), .idx(3));
    cycle(.st(1), .dn(1));
    check("stall_pc",   32'(pc),   32'd7);
    check("stall_done", 32'(done), 32'd0);

    // Halt at pc=12, then restart
    repeat (5) cycle();
    check("halt_pre_pc", 32'(pc), 32'd12);
    cycle(.dn(1));
    check("halt_done",  32'(done),        32'd1);
    check("halt_pc",    32'(pc),          32'd12);
    check("halt_instr", 32'(instruction), 32'd0);
    cycle(.s(1));
    check("restart2_pc",   32'(pc),   32'd0);
    check("restart2_done", 32'(done), 32'd0);

    // Reset aborting RUN at pc=9
    repeat (9) cycle();
    check("abort_pre_pc", 32'(pc), 32'd9);
    async_reset_check("abort");
    cycle();
    check("abort_idle_valid", 32'(instr_valid), 32'd0);

    // Wrap from 1023 to 0 via LUT[15]
    cycle(.s(1));
    cycle(.br(1), .idx(15));
    check("wrap_pre_pc",    32'(pc),          32'd1023);
    check("wrap_pre_instr", 32'(instruction), 32'h1C7);
    cycle();
    check("wrap_pc",    32'(pc),          32'd0);
    check("wrap_instr", 32'(instruction), 32'h0A4);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
